// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Memory-mapped UART transmitter on the core's data bus. Byte stores to
// TX_ADDR are buffered in a small FIFO and serialized onto uart_out, LSB
// first, with CLK_DIV clock cycles per bit. STAT_ADDR reads back a status
// word and accepts a write that clears the sticky overflow flag. Every
// store is ignored while intr is high.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> 8E1 frame (start, 8 data, even parity, stop)
//                      undefined -> 8N1 frame (start, 8 data, stop)
//   The register map is the same in both builds.
//
// Parameters:
//   CLK_DIV     clock cycles per UART bit (>= 2)
//   FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//   TX_ADDR     data register; a write pushes wdata[7:0]
//   STAT_ADDR   status register; a write with wdata[3] set clears overflow
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wen       store strobe from the core
//   addr_d    store / read address
//   wdata     store data
//   intr      interrupt in service; blocks all writes to this block
//   rdata     combinational read: {28'b0, overflow, full, empty, busy}
//             when addr_d == STAT_ADDR, otherwise 0
//   uart_out  serial line, idle high, driven straight from a flop
//   tx_busy   a frame is in progress or the FIFO still holds bytes
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] TX_ADDR    = 32'h1000,
   parameter logic [31:0] STAT_ADDR  = 32'h1004
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wen,
   input  logic [31:0] addr_d,
   input  logic [31:0] wdata,
   input  logic        intr,
   output logic [31:0] rdata,
   output logic        uart_out,
   output logic        tx_busy
);

   // Pointers carry one extra bit so that full and empty are distinct
   // values of (wptr - rptr) without a separate occupancy counter.
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
   localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic push_req;
   logic clr_req;
   logic push_ok;
   logic drop;

   assign push_req = wen && (addr_d == TX_ADDR)   && !intr;
   assign clr_req  = wen && (addr_d == STAT_ADDR) && !intr && wdata[3];

   // Only the low byte and the clear bit of the store data matter here.
   logic unused_wdata;
   assign unused_wdata = ^wdata[31:8];

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          pop;
   logic [7:0]    head;

   assign count = wptr - rptr;
   assign empty = (count == '0);
   assign full  = (count == DEPTH_P);
   assign head  = mem[rptr[AW-1:0]];

   // Fullness is taken from the pre-edge count, so a pop on the same edge
   // never makes room for the incoming byte.
   assign push_ok = push_req && !full;
   assign drop    = push_req &&  full;

   // NOTE: the storage array is deliberately left out of reset; an entry is
   // only ever read after the pointers show it was written, so clearing it
   // would add reset fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr[AW-1:0]] <= wdata[7:0];
      end
   end

   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // flops sample pre-edge values regardless of statement or block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         // A drop on the same edge as a clear leaves the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_req) begin
            overflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_next;
   logic [7:0]    shreg;
   logic [7:0]    shreg_next;
   logic          uart_next;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par;
   logic          par_next;
`endif

   assign bit_end = (cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         bit_idx  <= bit_idx_next;
         shreg    <= shreg_next;
         uart_out <= uart_next;
`ifdef UART_TX_PARITY_EN
         par      <= par_next;
`endif
      end
   end

   // The line value for the next bit is decided here and registered, so
   // uart_out changes exactly on the edge that starts each bit.
   // NOTE: every signal assigned in this block gets a default first; any
   // path that left one unassigned would infer a latch.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CW'(1);
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      uart_next    = uart_out;
      pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_next     = par;
`endif

      case (state)
         S_IDLE: begin
            cnt_next  = '0;
            uart_next = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               shreg_next = head;
`ifdef UART_TX_PARITY_EN
               par_next   = ^head;
`endif
               state_next = S_START;
               uart_next  = 1'b0;
            end
         end

         S_START: begin
            if (bit_end) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               state_next   = S_DATA;
               uart_next    = shreg[0];
            end
         end

         S_DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
                  uart_next  = par;
`else
                  state_next = S_STOP;
                  uart_next  = 1'b1;
`endif
               end else begin
                  // Bit 0 of the shift register is always the bit on the
                  // line; shift and present the next one.
                  bit_idx_next = bit_idx + 3'd1;
                  shreg_next   = {1'b0, shreg[7:1]};
                  uart_next    = shreg[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_next   = '0;
               state_next = S_STOP;
               uart_next  = 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               cnt_next = '0;
               // Chain straight into the next start bit when data is
               // waiting, so back-to-back bytes have no idle bit between.
               if (!empty) begin
                  pop        = 1'b1;
                  shreg_next = head;
`ifdef UART_TX_PARITY_EN
                  par_next   = ^head;
`endif
                  state_next = S_START;
                  uart_next  = 1'b0;
               end else begin
                  state_next = S_IDLE;
                  uart_next  = 1'b1;
               end
            end
         end

         default: begin
            cnt_next   = '0;
            state_next = S_IDLE;
            uart_next  = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Status
   // ------------------------------------------------------------------
   logic busy;

   assign busy    = (state != S_IDLE);
   assign tx_busy = busy || !empty;
   assign rdata   = (addr_d == STAT_ADDR) ? {28'b0, overflow, full, empty, busy}
                                          : 32'b0;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Scoreboard bench for uart_tx_ctrl at CLK_DIV=4, FIFO_DEPTH=8. The
// reference model is time based: for each accepted byte it records the edge
// it was pushed and the edge the transmitter will pick it up
// (max(push+1, previous pickup + frame length)), and derives occupancy,
// busy and overflow from those lists. Accepted bytes go into an expected
// queue; a serial-line monitor decodes each frame from uart_out and checks
// it against the head of the queue. A status checker compares rdata,
// tx_busy and the idle line with the model on every cycle.
// Honours UART_TX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   localparam int          CLK_DIV    = 4;
   localparam int          FIFO_DEPTH = 8;
   localparam logic [31:0] TX_ADDR    = 32'h1000;
   localparam logic [31:0] STAT_ADDR  = 32'h1004;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

   logic        clk;
   logic        rst_n;
   logic        wen;
   logic [31:0] addr_d;
   logic [31:0] wdata;
   logic        intr;
   logic [31:0] rdata;
   logic        uart_out;
   logic        tx_busy;

   uart_tx_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TX_ADDR   (TX_ADDR),
      .STAT_ADDR (STAT_ADDR)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wen     (wen),
      .addr_d  (addr_d),
      .wdata   (wdata),
      .intr    (intr),
      .rdata   (rdata),
      .uart_out(uart_out),
      .tx_busy (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of rising edges seen so far; at a falling edge it names the
   // edge whose results are currently visible.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int frames_rx = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      logic [7:0] data;
      int         pop;
   } exp_t;

   typedef struct {
      int c;
      bit set;
   } ovf_ev_t;

   int      push_c[$];
   int      pop_c[$];
   ovf_ev_t ovf_ev[$];
   exp_t    exp_q[$];
   int      last_pop = -100000;

   function automatic int occ_pre(input int t);
      int n = 0;
      foreach (push_c[i]) if (push_c[i] < t && pop_c[i] >= t) n++;
      return n;
   endfunction

   function automatic int occ_after(input int t);
      int n = 0;
      foreach (push_c[i]) if (push_c[i] <= t && pop_c[i] > t) n++;
      return n;
   endfunction

   function automatic bit fsm_busy(input int t);
      bit b = 1'b0;
      foreach (pop_c[i]) if (pop_c[i] <= t && t < pop_c[i] + FRAME_CYC) b = 1'b1;
      return b;
   endfunction

   function automatic bit ovf_after(input int t);
      bit v = 1'b0;
      foreach (ovf_ev[i]) if (ovf_ev[i].c <= t) v = ovf_ev[i].set;
      return v;
   endfunction

   function automatic logic [31:0] model_status(input int t);
      int occ = occ_after(t);
      return {28'b0, ovf_after(t), (occ == FIFO_DEPTH), (occ == 0), fsm_busy(t)};
   endfunction

   function automatic logic model_txbusy(input int t);
      return fsm_busy(t) || (occ_after(t) != 0);
   endfunction

   task automatic model_write(input int t, input logic [31:0] a, input logic [31:0] d, input logic irq);
      int p;
      exp_t e;
      if (irq) return;
      if (a == TX_ADDR) begin
         if (occ_pre(t) < FIFO_DEPTH) begin
            p = t + 1;
            if (last_pop + FRAME_CYC > p) p = last_pop + FRAME_CYC;
            push_c.push_back(t);
            pop_c.push_back(p);
            last_pop = p;
            e.data = d[7:0];
            e.pop  = p;
            exp_q.push_back(e);
         end else begin
            ovf_ev.push_back('{c: t, set: 1'b1});
         end
      end else if (a == STAT_ADDR && d[3]) begin
         ovf_ev.push_back('{c: t, set: 1'b0});
      end
   endtask

   task automatic model_reset();
      push_c.delete();
      pop_c.delete();
      ovf_ev.delete();
      exp_q.delete();
      last_pop = -100000;
   endtask

   // ------------------------------------------------------------------
   // Bus driver (one bus cycle per call, driven just after a falling edge)
   // ------------------------------------------------------------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic irq);
      @(negedge clk);
      wen    = 1'b1;
      addr_d = a;
      wdata  = d;
      intr   = irq;
      model_write(cyc + 1, a, d, irq);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      wen    = 1'b0;
      addr_d = STAT_ADDR;
      wdata  = 32'h0;
      intr   = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || model_txbusy(cyc)) && guard < 5000) begin
         bus_idle();
         guard++;
      end
      check("drain_timeout", 32'(guard < 5000), 32'h1);
   endtask

   // ------------------------------------------------------------------
   // Serial monitor: decodes frames and pops the scoreboard
   // ------------------------------------------------------------------
   task automatic receive_frame(input int start_c);
      logic [FRAME_BITS-1:0] bits;
      logic stable;
      logic aborted;
      exp_t e;
      bits    = '0;
      bits[0] = uart_out;
      stable  = 1'b1;
      aborted = 1'b0;
      for (int i = 1; i < FRAME_CYC; i++) begin
         @(negedge clk);
         if (!rst_n) begin
            aborted = 1'b1;
            break;
         end
         if (i % CLK_DIV == 0) bits[i / CLK_DIV] = uart_out;
         else if (uart_out !== bits[i / CLK_DIV]) stable = 1'b0;
      end
      if (!aborted) begin
         frames_rx++;
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("frame_data",        32'(bits[8:1]),            32'(e.data));
            check("frame_start_cycle", 32'(start_c),              32'(e.pop));
            check("frame_stop_bit",    32'(bits[FRAME_BITS-1]),   32'h1);
            check("frame_bit_stable",  32'(stable),               32'h1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity",      32'(bits[9]),              32'(^e.data));
`endif
         end
      end
   endtask

   initial begin : monitor
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b1;
         end else begin
            if (prev && !uart_out) receive_frame(cyc);
            prev = uart_out;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle status checker
   // ------------------------------------------------------------------
   initial begin : status_checker
      logic [31:0] exp_rd;
      forever begin
         @(negedge clk);
         #1;
         exp_rd = (addr_d == STAT_ADDR) ? model_status(cyc) : 32'h0;
         check("rdata", rdata, exp_rd);
         check("tx_busy", 32'(tx_busy), 32'(model_txbusy(cyc)));
         if (!fsm_busy(cyc)) check("idle_line", 32'(uart_out), 32'h1);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin : stimulus
      int p;
      int target;
      int frames_before;
      int op;
      int blen;

      rst_n  = 1'b0;
      wen    = 1'b0;
      addr_d = STAT_ADDR;
      wdata  = 32'h0;
      intr   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset_uart_out", 32'(uart_out), 32'h1);
      check("reset_tx_busy",  32'(tx_busy),  32'h0);
      check("reset_status",   rdata,         32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) bus_idle();

      // Single byte 0x41: tx_busy falls 40 cycles after the pickup edge
      bus_write(TX_ADDR, 32'h41, 1'b0);
      p = last_pop;
      while (cyc < p + 39) bus_idle();
      #1;
      check("single_busy_before_end", 32'(tx_busy), 32'h1);
      bus_idle();
      #1;
      check("single_busy_after_end", 32'(tx_busy), (FRAME_BITS == 10) ? 32'h0 : 32'h1);
      drain();

      // Burst of 10 consecutive writes while idle: the tenth is dropped
      for (int i = 0; i < 10; i++) bus_write(TX_ADDR, 32'h30 + 32'(i), 1'b0);
      bus_idle();
      #1;
      check("burst_status", rdata, 32'hD);
      bus_write(STAT_ADDR, 32'h8, 1'b0);
      bus_idle();
      #1;
      check("overflow_cleared", rdata & 32'h8, 32'h0);
      drain();

      // Filtering: interrupt-time store and an unmapped address
      frames_before = frames_rx;
      bus_write(TX_ADDR, 32'h55, 1'b1);
      bus_write(32'h1008, 32'h41, 1'b0);
      repeat (60) bus_idle();
      #1;
      check("filter_status", rdata, 32'h2);
      check("filter_no_frame", 32'(frames_rx), 32'(frames_before));

      // Parity example byte (plain 8N1 in the default build)
      bus_write(TX_ADDR, 32'h07, 1'b0);
      drain();

      // Reset during data bit 3 with bytes still queued
      bus_write(TX_ADDR, 32'hA5, 1'b0);
      p = last_pop;
      bus_write(TX_ADDR, 32'h3C, 1'b0);
      bus_write(TX_ADDR, 32'hF0, 1'b0);
      target = p + 4 * CLK_DIV + 1;
      while (cyc < target) bus_idle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midreset_uart_out", 32'(uart_out), 32'h1);
      check("midreset_status",   rdata,         32'h2);
      check("midreset_tx_busy",  32'(tx_busy),  32'h0);
      frames_before = frames_rx;
      repeat (3) bus_idle();
      #2;
      rst_n = 1'b1;
      repeat (100) bus_idle();
      check("midreset_no_frame", 32'(frames_rx), 32'(frames_before));

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            bus_write(TX_ADDR, $urandom, ($urandom_range(0, 7) == 0));
         end else if (op == 6) begin
            bus_write(STAT_ADDR, $urandom, ($urandom_range(0, 3) == 0));
         end else if (op == 7) begin
            bus_write(32'h1008 + 32'($urandom_range(0, 3) << 2), $urandom, 1'b0);
         end else if (op == 8) begin
            blen = $urandom_range(3, 12);
            for (int k = 0; k < blen; k++) bus_write(TX_ADDR, $urandom, 1'b0);
         end else begin
            blen = $urandom_range(1, 60);
            for (int k = 0; k < blen; k++) bus_idle();
         end
      end
      drain();
      repeat (5) bus_idle();
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
